// File: rtl/comp_search_pkg.sv
// rtl/comp_search_pkg.sv - shared types and sizing helpers for the comparator-driven search engine
package comp_search_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int steps_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/comp_search.sv
// rtl/comp_search.sv - MSB-first successive-approximation search using only comparator flags
module comp_search
    import comp_search_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            cmp_less,
    input  logic                            cmp_greater,
    input  logic                            cmp_eq,
    output logic [WIDTH-1:0]                guess,
    output logic                            busy,
    output logic                            done,
    output logic [WIDTH-1:0]                result,
    output logic [steps_width(WIDTH)-1:0]   steps,
    output logic                            err
);

    localparam int IW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    idx;
    logic             one_hot;
    logic             last;
    logic [WIDTH-1:0] guess_next;

    // Odd population count excluding the all-three case leaves exactly one flag set.
    assign one_hot = (cmp_less ^ cmp_greater ^ cmp_eq) & ~(cmp_less & cmp_greater & cmp_eq);
    assign last    = (idx == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        guess_next = guess;
        if (cmp_greater) begin
            guess_next[idx] = 1'b0;
        end
        if (!last) begin
            guess_next[idx - 1'b1] = 1'b1;
        end
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CMP;
                end
            end
            CMP: begin
                busy = 1'b1;
                if (!one_hot || cmp_eq || last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            guess  <= '0;
            idx    <= '0;
            steps  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        guess  <= {1'b1, {(WIDTH-1){1'b0}}};
                        idx    <= IW'(WIDTH - 1);
                        steps  <= '0;
                        err    <= 1'b0;
                    end
                end
                CMP: begin
                    steps <= steps + 1'b1;
                    if (!one_hot) begin
                        err    <= 1'b1;
                        result <= '0;
                    end else if (cmp_eq) begin
                        result <= guess;
                    end else begin
                        guess <= guess_next;
                        if (last) begin
                            result <= guess_next;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
